regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_pkg.sv | 24 ++
 rtl/regfile_write_arbiter_if.sv | 41 ++++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 30 +++
 rtl/regfile_write_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the default register-file geometry, the arbiter FSM state encoding,
// and the writeback request record used by requesters.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Legacy-compatible raw encodings, reused as the enum values.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    typedef enum logic [0:0] {
        INIT = ST_INIT,
        RUN  = ST_RUN
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the writeback requesters, the arbiter and the register file
// write port.
//   req0_*     : ALU writeback request (valid/addr/data in, ready out)
//   req1_*     : load writeback request (valid/addr/data in, ready out)
//   wa/wd/we   : register file A3 / WD / WE
//   init_done  : zero sweep finished
// modport master : requester / register-file side
// modport slave  : arbiter side
interface regfile_write_arbiter_if #(
    parameter int N = 5,
    parameter int M = 32
);
    logic         req0_valid;
    logic [N-1:0] req0_addr;
    logic [M-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [N-1:0] req1_addr;
    logic [M-1:0] req1_data;
    logic         req1_ready;
    logic [N-1:0] wa;
    logic [M-1:0] wd;
    logic         we;
    logic         init_done;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wa, wd, we, init_done
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wa, wd, we, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
//   clk, srst : clock, synchronous active-high reset (pointer -> 0)
//   en        : grants are only issued while high
//   req[1:0]  : requests
//   update    : a grant was consumed this cycle; advance the pointer
//   gnt[1:0]  : one-hot (or zero) grant, combinational
// The pointer names the requester that wins the next tie; after serving
// requester i it points at the other one.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic ptr_reg;

    assign gnt[0] = en & req[0] & (~req[1] | ~ptr_reg);
    assign gnt[1] = en & req[1] & (~req[0] |  ptr_reg);

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_reg <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            // Served 0 -> favour 1 next, served 1 -> favour 0 next.
            ptr_reg <= gnt[0];
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port.
// After reset it writes zero to every register (one per cycle, address
// 0..NUM_REGS-1), then shares the port between the ALU writeback (req0) and
// the load writeback (req1) with round-robin valid/ready arbitration.
// Writes are registered: an accepted request shows up on wa/wd/we one cycle
// later. Ports: clk, rst (synchronous, active high), bus (slave modport).
module regfile_write_arbiter #(
    parameter int N             = regfile_pkg::REG_ADDR_W,
    parameter int M             = regfile_pkg::REG_DATA_W,
    parameter int NUM_REGS      = 2**N,
    parameter bit ZERO_PROTECT  = 1'b1,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    import regfile_pkg::*;

    // One extra counter bit keeps the final sweep address unambiguous.
    localparam logic [N:0] CNT_LAST = (N+1)'(NUM_REGS - 1);

    arb_state_t   state_reg;
    logic [N:0]   cnt_reg;
    logic         we_reg;
    logic [N-1:0] wa_reg;
    logic [M-1:0] wd_reg;
    logic         init_done_reg;

    logic [1:0]   valid;
    logic [1:0]   gnt;
    logic [1:0]   blocked;
    logic [N-1:0] addr [2];
    logic [M-1:0] data [2];
    logic         sel;

    assign valid   = {bus.req1_valid, bus.req0_valid};
    assign addr[0] = bus.req0_addr;
    assign addr[1] = bus.req1_addr;
    assign data[0] = bus.req0_data;
    assign data[1] = bus.req1_data;

    // A write to register 0 is still accepted but must not assert WE.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_zero_guard
            assign blocked[gi] = ZERO_PROTECT && (addr[gi] == '0);
        end
    endgenerate

    rr_arbiter2 u_arb (
        .clk    (clk),
        .srst   (rst),
        .en     (state_reg == RUN),
        .req    (valid),
        .update (gnt != 2'b00),
        .gnt    (gnt)
    );

    assign sel = gnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_ON_RESET) begin
                state_reg <= INIT;
            end else begin
                state_reg <= RUN;
            end
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            wa_reg        <= '0;
            wd_reg        <= '0;
            init_done_reg <= !INIT_ON_RESET;
        end else begin
            case (state_reg)
                INIT: begin
                    we_reg  <= 1'b1;
                    wa_reg  <= cnt_reg[N-1:0];
                    wd_reg  <= '0;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                    if (gnt != 2'b00) begin
                        wa_reg <= addr[sel];
                        wd_reg <= data[sel];
                        we_reg <= !blocked[sel];
                    end else begin
                        // Idle edge: drop WE, keep the last address/data.
                        we_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.wa         = wa_reg;
    assign bus.wd         = wd_reg;
    assign bus.we         = we_reg;
    assign bus.init_done  = init_done_reg;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: init sweep, table of RUN-mode
// transactions with hand-computed results, and a reset issued mid-sweep.
module tb_regfile_write_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [31:0] rf [32];

    regfile_write_arbiter_if #(.N(5), .M(32)) bus_if ();

    regfile_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model fed by the write port.
    always @(posedge clk) begin
        if (bus_if.we) rf[bus_if.wa] <= bus_if.wd;
    end

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        bus_if.req0_valid = v0;
        bus_if.req0_addr  = a0;
        bus_if.req0_data  = d0;
        bus_if.req1_valid = v1;
        bus_if.req1_addr  = a1;
        bus_if.req1_data  = d1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hBAD0_0000 | 32'(i);

        // Pointer starts at 0 after the sweep.
        //          v0  a0     d0            v1  a1     d1            r0 r1 we wa     wd
        vecs[0]  = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd31, 32'h0};
        vecs[1]  = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        1, 0, 1, 5'd5,  32'hDEADBEEF};
        vecs[2]  = '{0, 5'd0,  32'h0,        1, 5'd0,  32'hFFFFFFFF, 0, 1, 0, 5'd0,  32'hFFFFFFFF};
        vecs[3]  = '{1, 5'd1,  32'h100,      1, 5'd9,  32'h900,      1, 0, 1, 5'd1,  32'h100};
        vecs[4]  = '{1, 5'd2,  32'h200,      1, 5'd9,  32'h900,      0, 1, 1, 5'd9,  32'h900};
        vecs[5]  = '{1, 5'd2,  32'h200,      1, 5'd10, 32'h1000,     1, 0, 1, 5'd2,  32'h200};
        vecs[6]  = '{1, 5'd3,  32'h300,      1, 5'd10, 32'h1000,     0, 1, 1, 5'd10, 32'h1000};
        vecs[7]  = '{1, 5'd3,  32'h300,      0, 5'd0,  32'h0,        1, 0, 1, 5'd3,  32'h300};
        vecs[8]  = '{1, 5'd7,  32'h11,       1, 5'd7,  32'h22,       0, 1, 1, 5'd7,  32'h22};
        vecs[9]  = '{1, 5'd7,  32'h11,       0, 5'd0,  32'h0,        1, 0, 1, 5'd7,  32'h11};
        vecs[10] = '{0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0, 5'd7,  32'h11};

        // Reset state
        rst = 1'b1;
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        step();
        check("rst_we", 32'(bus_if.we), 32'd0);
        check("rst_wa", 32'(bus_if.wa), 32'd0);
        check("rst_wd", bus_if.wd, 32'h0);
        check("rst_init_done", 32'(bus_if.init_done), 32'd0);
        check("rst_ready0", 32'(bus_if.req0_ready), 32'd0);
        check("rst_ready1", 32'(bus_if.req1_ready), 32'd0);

        // Initial sweep: 32 writes of zero, addresses 0..31
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step();
            check($sformatf("sweep%0d_we", k), 32'(bus_if.we), 32'd1);
            check($sformatf("sweep%0d_wa", k), 32'(bus_if.wa), 32'(k));
            check($sformatf("sweep%0d_wd", k), bus_if.wd, 32'h0);
            check($sformatf("sweep%0d_done", k), 32'(bus_if.init_done), 32'(k == 31));
        end

        // RUN-mode transaction table
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("v%0d_ready0", i), 32'(bus_if.req0_ready), 32'(vecs[i].r0));
            check($sformatf("v%0d_ready1", i), 32'(bus_if.req1_ready), 32'(vecs[i].r1));
            step();
            check($sformatf("v%0d_we", i), 32'(bus_if.we), 32'(vecs[i].we));
            check($sformatf("v%0d_wa", i), 32'(bus_if.wa), 32'(vecs[i].wa));
            check($sformatf("v%0d_wd", i), bus_if.wd, vecs[i].wd);
            $display("vec %0d: ready=%0b%0b we=%0b wa=%0d wd=0x%08h", i,
                     bus_if.req1_ready, bus_if.req0_ready, bus_if.we, bus_if.wa, bus_if.wd);
        end
        check("rf_r7", rf[7], 32'h11);
        check("rf_r0", rf[0], 32'h0);
        check("rf_r5", rf[5], 32'hDEADBEEF);
        check("rf_r10", rf[10], 32'h1000);

        // Reset in the middle of the sweep with both requests pending
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1, 5'd20, 32'hA0A0, 1, 5'd21, 32'hB1B1);
        for (int k = 0; k <= 12; k++) begin
            #1;
            check($sformatf("mid%0d_ready0", k), 32'(bus_if.req0_ready), 32'd0);
            check($sformatf("mid%0d_ready1", k), 32'(bus_if.req1_ready), 32'd0);
            step();
            check($sformatf("mid%0d_wa", k), 32'(bus_if.wa), 32'(k));
        end
        rst = 1'b1;
        #1;
        check("mid_rst_ready0", 32'(bus_if.req0_ready), 32'd0);
        step();
        check("mid_rst_we", 32'(bus_if.we), 32'd0);
        check("mid_rst_wa", 32'(bus_if.wa), 32'd0);
        check("mid_rst_wd", bus_if.wd, 32'h0);
        check("mid_rst_done", 32'(bus_if.init_done), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            check($sformatf("re%0d_ready0", k), 32'(bus_if.req0_ready), 32'd0);
            check($sformatf("re%0d_ready1", k), 32'(bus_if.req1_ready), 32'd0);
            step();
            check($sformatf("re%0d_we", k), 32'(bus_if.we), 32'd1);
            check($sformatf("re%0d_wa", k), 32'(bus_if.wa), 32'(k));
            check($sformatf("re%0d_done", k), 32'(bus_if.init_done), 32'(k == 31));
        end
        // First eligible cycle after the sweep: pointer reset to 0, req0 wins
        #1;
        check("post_ready0", 32'(bus_if.req0_ready), 32'd1);
        check("post_ready1", 32'(bus_if.req1_ready), 32'd0);
        step();
        check("post_wa0", 32'(bus_if.wa), 32'd20);
        check("post_wd0", bus_if.wd, 32'hA0A0);
        check("post_we0", 32'(bus_if.we), 32'd1);
        bus_if.req0_valid = 1'b0;
        #1;
        check("post_ready1b", 32'(bus_if.req1_ready), 32'd1);
        step();
        check("post_wa1", 32'(bus_if.wa), 32'd21);
        check("post_wd1", bus_if.wd, 32'hB1B1);
        drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        step();
        check("post_idle_we", 32'(bus_if.we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
